// File: rtl/glay_cache_req_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// Shared definitions for the compute-unit cache request arbiter.
//
// GLAY_GLOBALS_PKG : compute-unit wide widths (PE count, cache front-end
//                    address/data/strobe widths).
// GLAY_REQ_PKG     : arbiter FSM state enum, latched request struct and the
//                    default watchdog limit used with GLAY_CACHE_ARB_TIMEOUT_EN.
// ---------------------------------------------------------------------------
package GLAY_GLOBALS_PKG;
    localparam int NUM_GRAPH_PE          = 4;
    localparam int CACHE_FRONTEND_ADDR_W = 32;
    localparam int CACHE_FRONTEND_DATA_W = 32;
    localparam int CACHE_FRONTEND_NBYTES = CACHE_FRONTEND_DATA_W / 8;
endpackage

package GLAY_REQ_PKG;
    import GLAY_GLOBALS_PKG::*;

    localparam int CACHE_ARB_TIMEOUT_CYCLES = 4096;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } cache_arb_state_t;

    // Request as latched at grant time; held stable for the whole transaction.
    typedef struct packed {
        logic [CACHE_FRONTEND_ADDR_W-1:0] addr;
        logic [CACHE_FRONTEND_DATA_W-1:0] wdata;
        logic [CACHE_FRONTEND_NBYTES-1:0] wstrb;
    } CacheArbRequest;
endpackage

// File: rtl/glay_cache_req_arbiter_if.sv
// ---------------------------------------------------------------------------
// Bus bundle between the per-PE requesters, the arbiter and the cache front
// end.
//   req_*   : packed per-requester request ports (requester i at slice i),
//             plus one-hot ready/grant and shared read data back.
//   cache_* : single blocking cache request port.
// Modports:
//   master : arbiter view (consumes requests, drives the cache port).
//   slave  : environment view (requesters and cache).
// ---------------------------------------------------------------------------
interface glay_cache_req_arbiter_if #(
    parameter int NUM_REQ = GLAY_GLOBALS_PKG::NUM_GRAPH_PE,
    parameter int ADDR_W  = GLAY_GLOBALS_PKG::CACHE_FRONTEND_ADDR_W,
    parameter int DATA_W  = GLAY_GLOBALS_PKG::CACHE_FRONTEND_DATA_W,
    parameter int NBYTES  = GLAY_GLOBALS_PKG::CACHE_FRONTEND_NBYTES
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ*NBYTES-1:0] req_wstrb;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         req_rdata;
    logic [NUM_REQ-1:0]        req_grant;

    logic                      cache_valid;
    logic [ADDR_W-1:0]         cache_addr;
    logic [DATA_W-1:0]         cache_wdata;
    logic [NBYTES-1:0]         cache_wstrb;
    logic [DATA_W-1:0]         cache_rdata;
    logic                      cache_ready;

    modport master (
        input  req_valid, req_addr, req_wdata, req_wstrb,
        input  cache_rdata, cache_ready,
        output req_ready, req_rdata, req_grant,
        output cache_valid, cache_addr, cache_wdata, cache_wstrb
    );

    modport slave (
        output req_valid, req_addr, req_wdata, req_wstrb,
        output cache_rdata, cache_ready,
        input  req_ready, req_rdata, req_grant,
        input  cache_valid, cache_addr, cache_wdata, cache_wstrb
    );
endinterface

// File: rtl/glay_rr_priority_select.sv
// ---------------------------------------------------------------------------
// Combinational cyclic first-set search: finds the first set bit of i_valid
// at or after position i_ptr, wrapping from NUM_REQ-1 back to 0.
// Ports:
//   i_valid : request vector
//   i_ptr   : search start position (must be < NUM_REQ)
//   o_grant : one-hot winner (all zero when nothing is valid)
//   o_idx   : winner index (0 when nothing is valid)
//   o_any   : at least one request is valid
// ---------------------------------------------------------------------------
module glay_rr_priority_select #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_idx,
    output logic               o_any
);

    // Walk NUM_REQ positions starting at i_ptr; the first hit wins.
    always_comb begin
        int              w_pos;
        logic [PTR_W-1:0] w_pos_idx;
        o_grant   = '0;
        o_idx     = '0;
        o_any     = 1'b0;
        w_pos     = 0;
        w_pos_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = int'(i_ptr) + k;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end else begin
                w_pos = w_pos;
            end
            w_pos_idx = PTR_W'(w_pos);
            if (!o_any && i_valid[w_pos_idx]) begin
                o_any              = 1'b1;
                o_grant[w_pos_idx] = 1'b1;
                o_idx              = w_pos_idx;
            end else begin
                o_any = o_any;
            end
        end
    end

endmodule

// File: rtl/glay_cache_req_arbiter.sv
// ---------------------------------------------------------------------------
// Round-robin arbiter/sequencer sharing the single blocking cache front end
// among NUM_REQ engine requesters. One request is in flight at a time:
// IDLE (arbitrate) -> BUSY (cache_valid held until cache_ready) -> RESP
// (one-cycle req_ready pulse with read data) -> IDLE.
//
// Ports:
//   ap_clk, ap_rst_n : clock, synchronous active-low reset
//   arb_enable       : allow new grants (in-flight work always completes)
//   arb_idle         : FSM in IDLE with nothing in flight
//   bus              : request/cache bundle, master modport
//   arb_timeout      : sticky watchdog flag (only with the macro below)
//
// Optional feature macro: GLAY_CACHE_ARB_TIMEOUT_EN
//   Counts BUSY cycles per transaction; when the count reaches
//   TIMEOUT_CYCLES the sticky arb_timeout flag sets. The transaction keeps
//   waiting for the cache.
// ---------------------------------------------------------------------------
module glay_cache_req_arbiter
    import GLAY_GLOBALS_PKG::*;
    import GLAY_REQ_PKG::*;
#(
    parameter int NUM_REQ        = NUM_GRAPH_PE,
    parameter int ADDR_W         = CACHE_FRONTEND_ADDR_W,
    parameter int DATA_W         = CACHE_FRONTEND_DATA_W,
    parameter int NBYTES         = CACHE_FRONTEND_NBYTES,
    parameter int TIMEOUT_CYCLES = CACHE_ARB_TIMEOUT_CYCLES
) (
    input  logic ap_clk,
    input  logic ap_rst_n,
    input  logic arb_enable,
    output logic arb_idle,
`ifdef GLAY_CACHE_ARB_TIMEOUT_EN
    output logic arb_timeout,
`endif
    glay_cache_req_arbiter_if.master bus
);

    localparam int               PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    cache_arb_state_t   r_state, w_state_nxt;
    logic [PTR_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
    logic [NUM_REQ-1:0] r_ready, w_ready_nxt;
    logic [DATA_W-1:0]  r_rdata, w_rdata_nxt;
    logic               r_cache_valid, w_cache_valid_nxt;
    logic               r_idle, w_idle_nxt;
    CacheArbRequest     r_req, w_req_nxt;

    logic [NUM_REQ-1:0] w_sel_grant;
    logic [PTR_W-1:0]   w_sel_idx;
    logic               w_any_valid;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;
    logic [NBYTES-1:0]  w_sel_wstrb;

    glay_rr_priority_select #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_select (
        .i_valid (bus.req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_sel_grant),
        .o_idx   (w_sel_idx),
        .o_any   (w_any_valid)
    );

    assign w_sel_addr  = bus.req_addr[int'(w_sel_idx)*ADDR_W +: ADDR_W];
    assign w_sel_wdata = bus.req_wdata[int'(w_sel_idx)*DATA_W +: DATA_W];
    assign w_sel_wstrb = bus.req_wstrb[int'(w_sel_idx)*NBYTES +: NBYTES];

    // Next-state and next-output logic; every output comes from a register.
    always_comb begin
        w_state_nxt       = r_state;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_grant_nxt       = r_grant;
        w_ready_nxt       = '0;
        w_rdata_nxt       = r_rdata;
        w_cache_valid_nxt = r_cache_valid;
        w_req_nxt         = r_req;
        case (r_state)
            IDLE: begin
                if (arb_enable && w_any_valid) begin
                    w_state_nxt       = BUSY;
                    w_grant_nxt       = w_sel_grant;
                    w_cache_valid_nxt = 1'b1;
                    w_rr_ptr_nxt      = (w_sel_idx == LAST_IDX) ? '0 : w_sel_idx + PTR_W'(1);
                    w_req_nxt.addr    = CACHE_FRONTEND_ADDR_W'(w_sel_addr);
                    w_req_nxt.wdata   = CACHE_FRONTEND_DATA_W'(w_sel_wdata);
                    w_req_nxt.wstrb   = CACHE_FRONTEND_NBYTES'(w_sel_wstrb);
                end else begin
                    w_state_nxt       = IDLE;
                    w_grant_nxt       = '0;
                    w_cache_valid_nxt = 1'b0;
                end
            end
            BUSY: begin
                if (bus.cache_ready) begin
                    w_state_nxt       = RESP;
                    w_rdata_nxt       = bus.cache_rdata;
                    w_ready_nxt       = r_grant;
                    w_grant_nxt       = '0;
                    w_cache_valid_nxt = 1'b0;
                end else begin
                    w_state_nxt       = BUSY;
                end
            end
            RESP: begin
                w_state_nxt       = IDLE;
                w_grant_nxt       = '0;
                w_cache_valid_nxt = 1'b0;
            end
            default: begin
                w_state_nxt       = IDLE;
                w_grant_nxt       = '0;
                w_cache_valid_nxt = 1'b0;
            end
        endcase
    end

    assign w_idle_nxt = (w_state_nxt == IDLE);

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_state       <= IDLE;
            r_rr_ptr      <= '0;
            r_grant       <= '0;
            r_ready       <= '0;
            r_rdata       <= '0;
            r_cache_valid <= 1'b0;
            r_idle        <= 1'b1;
            r_req         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_grant       <= w_grant_nxt;
            r_ready       <= w_ready_nxt;
            r_rdata       <= w_rdata_nxt;
            r_cache_valid <= w_cache_valid_nxt;
            r_idle        <= w_idle_nxt;
            r_req         <= w_req_nxt;
        end
    end

    assign arb_idle        = r_idle;
    assign bus.req_grant   = r_grant;
    assign bus.req_ready   = r_ready;
    assign bus.req_rdata   = r_rdata;
    assign bus.cache_valid = r_cache_valid;
    assign bus.cache_addr  = ADDR_W'(r_req.addr);
    assign bus.cache_wdata = DATA_W'(r_req.wdata);
    assign bus.cache_wstrb = NBYTES'(r_req.wstrb);

`ifdef GLAY_CACHE_ARB_TIMEOUT_EN
    localparam int             CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_to_cnt, w_to_cnt_nxt;
    logic             r_timeout, w_timeout_nxt;

    // BUSY-cycle watchdog: clear on grant, count while BUSY, saturate at limit.
    always_comb begin
        w_to_cnt_nxt  = r_to_cnt;
        w_timeout_nxt = r_timeout;
        if (r_state == IDLE && w_state_nxt == BUSY) begin
            w_to_cnt_nxt = '0;
        end else if (r_state == BUSY && r_to_cnt != CNT_MAX) begin
            w_to_cnt_nxt = r_to_cnt + CNT_W'(1);
        end else begin
            w_to_cnt_nxt = r_to_cnt;
        end
        if (r_state == BUSY && w_to_cnt_nxt == CNT_MAX) begin
            w_timeout_nxt = 1'b1;
        end else begin
            w_timeout_nxt = r_timeout;
        end
    end

    // Watchdog registers; the flag is sticky until reset.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_to_cnt  <= w_to_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign arb_timeout = r_timeout;
`endif

endmodule

// File: tb/tb_glay_cache_req_arbiter.sv
module tb_glay_cache_req_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NB = 4;

    logic ap_clk = 1'b0;
    logic ap_rst_n;
    logic arb_enable;
    logic arb_idle;
`ifdef GLAY_CACHE_ARB_TIMEOUT_EN
    logic arb_timeout;
`endif

    glay_cache_req_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .NBYTES(NB)) bus ();

    glay_cache_req_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .NBYTES(NB), .TIMEOUT_CYCLES(8)
    ) dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .arb_enable (arb_enable),
        .arb_idle   (arb_idle),
`ifdef GLAY_CACHE_ARB_TIMEOUT_EN
        .arb_timeout(arb_timeout),
`endif
        .bus        (bus)
    );

    always #5 ap_clk = ~ap_clk;

    int total = 0;
    int bad   = 0;

    logic          t_valid [N];
    logic [AW-1:0] t_addr  [N];
    logic [DW-1:0] t_wdata [N];
    logic [NB-1:0] t_wstrb [N];

    task automatic drive_bus();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]            = t_valid[i];
            bus.req_addr[i*AW +: AW]    = t_addr[i];
            bus.req_wdata[i*DW +: DW]   = t_wdata[i];
            bus.req_wstrb[i*NB +: NB]   = t_wstrb[i];
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [NB-1:0] s);
        t_valid[i] = v; t_addr[i] = a; t_wdata[i] = d; t_wstrb[i] = s;
        drive_bus();
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < N; i++) begin
            t_valid[i] = 1'b0; t_addr[i] = '0; t_wdata[i] = '0; t_wstrb[i] = '0;
        end
        drive_bus();
        bus.cache_ready = 1'b0;
        bus.cache_rdata = '0;
        arb_enable      = 1'b1;
    endtask

    task automatic tick();
        @(negedge ap_clk);
    endtask

    task automatic do_reset();
        clear_inputs();
        ap_rst_n = 1'b0;
        tick(); tick();
        ap_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        ap_rst_n = 1'b0;
        tick(); tick();
        total++; if (bus.cache_valid !== 1'b0) begin bad++; $display("FAIL reset_cache_valid got=%0b exp=0", bus.cache_valid); end
        total++; if (bus.req_grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b exp=0000", bus.req_grant); end
        total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); end
        total++; if (bus.req_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", bus.req_rdata); end
        total++; if (bus.cache_addr !== 32'h0 || bus.cache_wstrb !== 4'h0) begin bad++; $display("FAIL reset_cache_req got=%h/%h exp=0/0", bus.cache_addr, bus.cache_wstrb); end
        total++; if (arb_idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%0b exp=1", arb_idle); end
`ifdef GLAY_CACHE_ARB_TIMEOUT_EN
        total++; if (arb_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%0b exp=0", arb_timeout); end
`endif
        ap_rst_n = 1'b1;
        tick();
        total++; if (arb_idle !== 1'b1 || bus.cache_valid !== 1'b0) begin bad++; $display("FAIL reset_quiet idle=%0b cv=%0b exp=1/0", arb_idle, bus.cache_valid); end
    endtask

    // Requester 2 reads 0x40, then requester 1 writes with rr_ptr at 3.
    task automatic test_single_read_and_wrap();
        do_reset();
        set_req(2, 1'b1, 32'h40, 32'h0, 4'h0);
        tick();
        total++; if (bus.cache_valid !== 1'b1 || bus.req_grant !== 4'b0100) begin bad++; $display("FAIL single_grant cv=%0b grant=%b exp=1/0100", bus.cache_valid, bus.req_grant); end
        total++; if (bus.cache_addr !== 32'h40 || bus.cache_wstrb !== 4'h0) begin bad++; $display("FAIL single_cache_req got=%h/%h exp=40/0", bus.cache_addr, bus.cache_wstrb); end
        total++; if (arb_idle !== 1'b0) begin bad++; $display("FAIL single_not_idle got=%0b exp=0", arb_idle); end
        for (int c = 0; c < 4; c++) begin
            tick();
            total++; if (bus.cache_valid !== 1'b1 || bus.cache_addr !== 32'h40 || bus.req_ready !== 4'b0) begin bad++; $display("FAIL single_hold c=%0d cv=%0b addr=%h ready=%b exp=1/40/0000", c, bus.cache_valid, bus.cache_addr, bus.req_ready); end
        end
        bus.cache_ready = 1'b1; bus.cache_rdata = 32'hDEAD;
        tick();
        bus.cache_ready = 1'b0;
        total++; if (bus.req_ready !== 4'b0100 || bus.req_rdata !== 32'hDEAD) begin bad++; $display("FAIL single_resp ready=%b rdata=%h exp=0100/dead", bus.req_ready, bus.req_rdata); end
        total++; if (bus.cache_valid !== 1'b0 || bus.req_grant !== 4'b0) begin bad++; $display("FAIL single_resp_release cv=%0b grant=%b exp=0/0000", bus.cache_valid, bus.req_grant); end
        total++; if (dut.r_rr_ptr !== 2'd3) begin bad++; $display("FAIL single_rr_ptr got=%0d exp=3", dut.r_rr_ptr); end
        set_req(2, 1'b0, 32'h0, 32'h0, 4'h0);
        set_req(1, 1'b1, 32'h88, 32'h1234, 4'hF);
        tick();
        total++; if (arb_idle !== 1'b1 || bus.req_ready !== 4'b0) begin bad++; $display("FAIL single_back_idle idle=%0b ready=%b exp=1/0000", arb_idle, bus.req_ready); end
        tick();
        total++; if (bus.req_grant !== 4'b0010 || bus.cache_addr !== 32'h88 || bus.cache_wdata !== 32'h1234 || bus.cache_wstrb !== 4'hF) begin bad++; $display("FAIL wrap_grant grant=%b addr=%h wd=%h ws=%h exp=0010/88/1234/f", bus.req_grant, bus.cache_addr, bus.cache_wdata, bus.cache_wstrb); end
        total++; if (dut.r_rr_ptr !== 2'd2) begin bad++; $display("FAIL wrap_rr_ptr got=%0d exp=2", dut.r_rr_ptr); end
        bus.cache_ready = 1'b1;
        tick();
        bus.cache_ready = 1'b0;
        set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
        total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL wrap_ready got=%b exp=0010", bus.req_ready); end
        tick();
    endtask

    // All requesters valid from reset; cache answers in the first BUSY cycle.
    task automatic test_contention();
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int n_grants = 0;
        int last_cyc = -1;
        int last_g   = 0;
        clear_inputs();
        ap_rst_n = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'h100 + 32'(i), 32'h0, 4'h0);
        tick(); tick();
        ap_rst_n = 1'b1;
        for (int cyc = 0; cyc < 40 && n_grants < 5; cyc++) begin
            tick();
            bus.cache_ready = 1'b0;
            if (bus.cache_valid === 1'b1) begin
                total++; if (bus.req_grant !== 4'(1 << exp_order[n_grants])) begin bad++; $display("FAIL contention_grant n=%0d got=%b exp=%0d", n_grants, bus.req_grant, exp_order[n_grants]); end
                total++; if (bus.cache_addr !== t_addr[exp_order[n_grants]]) begin bad++; $display("FAIL contention_addr n=%0d got=%h exp=%h", n_grants, bus.cache_addr, t_addr[exp_order[n_grants]]); end
                if (last_cyc >= 0) begin
                    total++; if (cyc - last_cyc != 3) begin bad++; $display("FAIL contention_spacing got=%0d exp=3", cyc - last_cyc); end
                end
                last_cyc = cyc;
                last_g   = exp_order[n_grants];
                n_grants++;
                bus.cache_ready = 1'b1;
                bus.cache_rdata = 32'hA0 + 32'(last_g);
            end else if (bus.req_ready !== 4'b0) begin
                total++; if (bus.req_ready !== 4'(1 << last_g) || bus.req_rdata !== 32'hA0 + 32'(last_g)) begin bad++; $display("FAIL contention_ready got=%b/%h exp=%0d", bus.req_ready, bus.req_rdata, last_g); end
                set_req(last_g, 1'b1, 32'h200 + 32'(last_g), 32'h0, 4'h0);
            end
        end
        total++; if (n_grants != 5) begin bad++; $display("FAIL contention_timeout grants=%0d exp=5", n_grants); end
        bus.cache_ready = 1'b0;
    endtask

    task automatic test_drain();
        do_reset();
        set_req(0, 1'b1, 32'h10, 32'h0, 4'h0);
        tick();
        arb_enable = 1'b0;
        set_req(3, 1'b1, 32'h30, 32'h0, 4'h0);
        tick(); tick();
        total++; if (bus.cache_valid !== 1'b1 || bus.req_grant !== 4'b0001) begin bad++; $display("FAIL drain_inflight cv=%0b grant=%b exp=1/0001", bus.cache_valid, bus.req_grant); end
        bus.cache_ready = 1'b1; bus.cache_rdata = 32'h5A5A;
        tick();
        bus.cache_ready = 1'b0;
        set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
        total++; if (bus.req_ready !== 4'b0001 || bus.req_rdata !== 32'h5A5A) begin bad++; $display("FAIL drain_complete ready=%b rdata=%h exp=0001/5a5a", bus.req_ready, bus.req_rdata); end
        for (int c = 0; c < 4; c++) begin
            tick();
            total++; if (arb_idle !== 1'b1 || bus.req_grant !== 4'b0 || bus.cache_valid !== 1'b0) begin bad++; $display("FAIL drain_hold c=%0d idle=%0b grant=%b cv=%0b exp=1/0000/0", c, arb_idle, bus.req_grant, bus.cache_valid); end
        end
        arb_enable = 1'b1;
        tick();
        total++; if (bus.req_grant !== 4'b1000 || bus.cache_valid !== 1'b1 || arb_idle !== 1'b0) begin bad++; $display("FAIL drain_resume grant=%b cv=%0b idle=%0b exp=1000/1/0", bus.req_grant, bus.cache_valid, arb_idle); end
        bus.cache_ready = 1'b1;
        tick();
        bus.cache_ready = 1'b0;
        set_req(3, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
    endtask

    task automatic test_reset_in_busy();
        do_reset();
        set_req(2, 1'b1, 32'h77, 32'h0, 4'h0);
        tick();
        ap_rst_n = 1'b0;
        tick();
        ap_rst_n = 1'b1;
        set_req(2, 1'b0, 32'h0, 32'h0, 4'h0);
        total++; if (bus.cache_valid !== 1'b0 || bus.req_grant !== 4'b0 || bus.req_ready !== 4'b0 || arb_idle !== 1'b1) begin bad++; $display("FAIL rstbusy_outputs cv=%0b grant=%b ready=%b idle=%0b exp=0/0000/0000/1", bus.cache_valid, bus.req_grant, bus.req_ready, arb_idle); end
        bus.cache_ready = 1'b1;
        tick();
        bus.cache_ready = 1'b0;
        total++; if (bus.req_ready !== 4'b0 || bus.cache_valid !== 1'b0) begin bad++; $display("FAIL rstbusy_no_pulse ready=%b cv=%0b exp=0000/0", bus.req_ready, bus.cache_valid); end
        tick();
        total++; if (bus.req_ready !== 4'b0 || arb_idle !== 1'b1) begin bad++; $display("FAIL rstbusy_quiet ready=%b idle=%0b exp=0000/1", bus.req_ready, arb_idle); end
    endtask

`ifdef GLAY_CACHE_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        set_req(0, 1'b1, 32'h44, 32'h0, 4'h0);
        tick();
        for (int k = 1; k < 20; k++) begin
            tick();
            total++; if (arb_timeout !== (k >= 8) || bus.cache_valid !== 1'b1) begin bad++; $display("FAIL timeout_flag k=%0d got=%0b cv=%0b exp=%0b/1", k, arb_timeout, bus.cache_valid, (k >= 8)); end
        end
        bus.cache_ready = 1'b1;
        tick();
        bus.cache_ready = 1'b0;
        set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
        total++; if (bus.req_ready !== 4'b0001 || arb_timeout !== 1'b1) begin bad++; $display("FAIL timeout_late_done ready=%b to=%0b exp=0001/1", bus.req_ready, arb_timeout); end
        tick(); tick();
        total++; if (arb_timeout !== 1'b1) begin bad++; $display("FAIL timeout_sticky got=%0b exp=1", arb_timeout); end
    endtask
`endif

    // Random traffic against a transaction-level reference of the arbiter.
    task automatic test_random();
        int            m_phase = 0;   // 0 waiting to grant, 1 cache busy, 2 responding
        int            m_ptr   = 0;
        int            m_g     = 0;
        logic [AW-1:0] m_addr  = '0;
        logic [DW-1:0] m_wdata = '0;
        logic [NB-1:0] m_wstrb = '0;
        logic [DW-1:0] m_rdata = '0;
        logic          p_en, p_cready;
        logic [DW-1:0] p_crdata;
        logic          p_valid [N];
        logic [AW-1:0] p_addr  [N];
        logic [DW-1:0] p_wdata [N];
        logic [NB-1:0] p_wstrb [N];
        do_reset();
        p_en = arb_enable; p_cready = 1'b0; p_crdata = '0;
        for (int i = 0; i < N; i++) begin
            p_valid[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0; p_wstrb[i] = '0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if (m_phase == 0) begin
                bit found = 1'b0;
                if (p_en) begin
                    for (int k = 0; k < N; k++) begin
                        int c = (m_ptr + k) % N;
                        if (!found && p_valid[c]) begin found = 1'b1; m_g = c; end
                    end
                end
                if (found) begin
                    m_ptr = (m_g + 1) % N;
                    m_addr = p_addr[m_g]; m_wdata = p_wdata[m_g]; m_wstrb = p_wstrb[m_g];
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (p_cready) begin m_rdata = p_crdata; m_phase = 2; end
            end else begin
                m_phase = 0;
            end
            total++; if (bus.cache_valid !== (m_phase == 1)) begin bad++; $display("FAIL rand_cache_valid cyc=%0d got=%0b exp=%0b", cyc, bus.cache_valid, (m_phase == 1)); end
            total++; if (bus.req_grant !== ((m_phase == 1) ? 4'(1 << m_g) : 4'b0)) begin bad++; $display("FAIL rand_grant cyc=%0d got=%b exp_idx=%0d phase=%0d", cyc, bus.req_grant, m_g, m_phase); end
            total++; if (bus.req_ready !== ((m_phase == 2) ? 4'(1 << m_g) : 4'b0)) begin bad++; $display("FAIL rand_ready cyc=%0d got=%b exp_idx=%0d phase=%0d", cyc, bus.req_ready, m_g, m_phase); end
            total++; if (arb_idle !== (m_phase == 0)) begin bad++; $display("FAIL rand_idle cyc=%0d got=%0b exp=%0b", cyc, arb_idle, (m_phase == 0)); end
            if (m_phase == 1) begin
                total++; if (bus.cache_addr !== m_addr || bus.cache_wdata !== m_wdata || bus.cache_wstrb !== m_wstrb) begin bad++; $display("FAIL rand_cache_req cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc, bus.cache_addr, bus.cache_wdata, bus.cache_wstrb, m_addr, m_wdata, m_wstrb); end
            end
            if (m_phase == 2) begin
                total++; if (bus.req_rdata !== m_rdata) begin bad++; $display("FAIL rand_rdata cyc=%0d got=%h exp=%h", cyc, bus.req_rdata, m_rdata); end
            end
            // New stimulus for the next edge.
            for (int i = 0; i < N; i++) begin
                bit holding = (m_phase == 1) && (m_g == i);
                if (m_phase == 2 && m_g == i) begin
                    set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
                end else if (!t_valid[i]) begin
                    if ($urandom_range(0, 9) < 3) set_req(i, 1'b1, $urandom, $urandom, 4'($urandom_range(0, 15)));
                end else if (!holding && $urandom_range(0, 4) == 0) begin
                    set_req(i, 1'b1, $urandom, $urandom, 4'($urandom_range(0, 15)));
                end
            end
            arb_enable      = ($urandom_range(0, 9) != 0);
            bus.cache_rdata = $urandom;
            if (m_phase == 1) bus.cache_ready = ($urandom_range(0, 3) == 0);
            else              bus.cache_ready = ($urandom_range(0, 7) == 0);
            p_en = arb_enable; p_cready = bus.cache_ready; p_crdata = bus.cache_rdata;
            for (int i = 0; i < N; i++) begin
                p_valid[i] = t_valid[i]; p_addr[i] = t_addr[i]; p_wdata[i] = t_wdata[i]; p_wstrb[i] = t_wstrb[i];
            end
        end
        clear_inputs();
        tick(); tick(); tick();
    endtask

    initial begin
        ap_rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_single_read_and_wrap();
        test_contention();
        test_drain();
        test_reset_in_busy();
`ifdef GLAY_CACHE_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/glay_cache_req_arbiter.md
# glay_cache_req_arbiter

Round-robin arbiter and sequencer that shares the compute unit's single blocking AXI-port cache front end among `NUM_REQ` engine requesters. It sits between the per-PE request ports and the cache request FIFO/cache interface inside the kernel compute unit. It grants one request at a time, holds the cache `valid` until the cache returns `ready`, and routes the read data back to the granted requester. It also exposes an enable/idle pair so the kernel control can drain the cache before done or invalidate.

## Interface
Parameters:
- `NUM_REQ`, default `NUM_GRAPH_PE`: number of requesters, 1–16.
- `ADDR_W`, default `CACHE_FRONTEND_ADDR_W`: request address width.
- `DATA_W`, default `CACHE_FRONTEND_DATA_W`: request data width.
- `NBYTES`, default `CACHE_FRONTEND_NBYTES`: write-strobe width.
- `TIMEOUT_CYCLES`, default 4096: watchdog limit; used only with `GLAY_CACHE_ARB_TIMEOUT_EN`.

Ports:
- `ap_clk`  in  1  clock.
- `ap_rst_n`  in  1  reset; synchronous, active-low.
- `arb_enable`  in  1  allow new grants.
- `arb_idle`  out  1  no transaction in flight and state is IDLE.
- `req_valid`  in  NUM_REQ  per-requester request valid; held until that requester's `req_ready`.
- `req_addr`  in  NUM_REQ*ADDR_W  packed addresses, requester i at slice i.
- `req_wdata`  in  NUM_REQ*DATA_W  packed write data.
- `req_wstrb`  in  NUM_REQ*NBYTES  packed strobes; all zero means read.
- `req_ready`  out  NUM_REQ  one-hot completion pulse.
- `req_rdata`  out  DATA_W  read data; valid only while `req_ready` is nonzero.
- `req_grant`  out  NUM_REQ  one-hot current grant.
- `cache_valid`  out  1  cache request valid.
- `cache_addr`  out  ADDR_W  cache request address.
- `cache_wdata`  out  DATA_W  cache write data.
- `cache_wstrb`  out  NBYTES  cache write strobe.
- `cache_rdata`  in  DATA_W  cache read data.
- `cache_ready`  in  1  cache completion, one-cycle pulse.
- `arb_timeout`  out  1  sticky watchdog flag; port exists only with the macro.

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE**
  - If `arb_enable` is high and any `req_valid` is set, select the first set bit at or after `rr_ptr`, searching cyclically.
  - Register the selected requester's addr, wdata and wstrb; set `req_grant` to that requester.
  - Set `rr_ptr` to (granted+1) mod NUM_REQ; go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY**
  - `cache_valid`=1 with the registered request held stable.
  - On `cache_ready`, capture `cache_rdata` and go to RESP.
- **RESP**
  - `req_ready[granted]`=1 and `req_rdata` = captured data for exactly one cycle.
  - `cache_valid`=0 and `req_grant`=0; go to IDLE.
- The requester must drop `req_valid` or present a new request in the cycle after `req_ready`. The arbiter re-arbitrates in that IDLE cycle.
- `arb_enable` low:
  - An in-flight transaction completes normally.
  - No new grant is issued.
  - `arb_idle`=1 once the FSM is back in IDLE.
- `req_valid` bits of non-granted requesters are ignored while BUSY or RESP. Changes on their data inputs have no effect.
- `cache_ready` outside BUSY is ignored.

## Timing
- Reset values:
  - All outputs 0, except `arb_idle`=1.
  - `rr_ptr`=0, state IDLE, `arb_timeout`=0.
- Reset taken in any state returns to IDLE on the next edge. Any in-flight request is abandoned; the parent resets the cache in the same cycle.
- Latency, request to `cache_valid`: 1 cycle, if `req_valid` is high in IDLE at edge t, `cache_valid` is high from t+1.
- Latency, `cache_ready` to `req_ready`: 1 cycle.
- Minimum transaction time is 3 cycles (IDLE, BUSY, RESP) when `cache_ready` arrives in the first BUSY cycle. Peak throughput is one request per 3 cycles.
- Fairness: with all requesters continuously valid, grant order is 0,1,…,NUM_REQ-1,0,…, and no requester waits more than NUM_REQ transactions.
- `rr_ptr` wraps from NUM_REQ-1 to 0.

## Configuration
- Macro `GLAY_CACHE_ARB_TIMEOUT_EN`:
  - **Defined:** a BUSY-cycle counter clears on entry to BUSY. When the counter reaches `TIMEOUT_CYCLES`, `arb_timeout` sets and stays set until reset. The transaction continues waiting; the counter saturates.
  - **Undefined:** no counter, `arb_timeout` port absent, FSM unchanged.

## Structure
- The `GLAY_REQ_PKG` package holds:
  - the state enum `cache_arb_state_t` (IDLE/BUSY/RESP);
  - the request struct `CacheArbRequest` (addr, wdata, wstrb);
  - the default `CACHE_ARB_TIMEOUT_CYCLES`.
- Cache width constants stay in `GLAY_GLOBALS_PKG`.
- One sub-module, `glay_rr_priority_select`: combinational cyclic first-set search over `req_valid` from `rr_ptr`, returning a one-hot grant and an index.

## Test plan
- **Single read.** NUM_REQ=4; requester 2 reads addr 0x40; cache returns `cache_ready` 5 cycles after `cache_valid`, with `cache_rdata`=0xDEAD. Expect `cache_valid` at t+1, `req_ready`=4'b0100 with `req_rdata`=0xDEAD one cycle after `cache_ready`, and `rr_ptr`=3.
- **Simultaneous contention.** All 4 requesters valid from reset, cache ready immediately. Expect grants 0,1,2,3,0 in successive 3-cycle windows.
- **Wrap-around.** `rr_ptr`=3 and only requester 1 valid. Expect grant to 1 and `rr_ptr`=2.
- **Drain.** Drop `arb_enable` during BUSY. Expect the transaction to complete, `arb_idle`=1 after RESP, and no grant while another requester stays valid. Raise `arb_enable` again and expect a grant on the next cycle.
- **Reset in BUSY.** Assert `ap_rst_n`=0 for 1 cycle. Expect all outputs 0 and `arb_idle`=1 next cycle, and no `req_ready` pulse for the abandoned request.
- **Timeout** (macro defined, `TIMEOUT_CYCLES`=8). Withhold `cache_ready` for 20 cycles. Expect `arb_timeout`=1 after 8 BUSY cycles and still set after the late `cache_ready` completes.
